// File: rtl/debounce_bank_pkg.sv
// Shared types and sizing helper for the push-button debouncer bank.
// Optional build macro: DEBOUNCE_AUTOREPEAT_EN (auto-repeat press pulses).
package debounce_pkg;

  typedef enum logic {DB_STABLE, DB_COUNTING} db_state_t;

  // Counter width covering the largest of the debounce and repeat intervals.
  function automatic int cnt_width(int debounce_cycles, int repeat_delay, int repeat_period);
    int m;
    m = debounce_cycles;
    if (repeat_delay > m) m = repeat_delay;
    if (repeat_period > m) m = repeat_period;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/debounce_bank_if.sv
// Button bank bus: raw inputs toward the debouncer, qualified levels and pulses back out.
interface debounce_bank_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] btn_in;
  logic [N_CH-1:0] btn_level;
  logic [N_CH-1:0] btn_press;
  logic [N_CH-1:0] btn_release;
  logic            any_press;

  modport master (
    output btn_in,
    input  btn_level, btn_press, btn_release, any_press
  );

  modport slave (
    input  btn_in,
    output btn_level, btn_press, btn_release, any_press
  );
endinterface

// File: rtl/debounce_bank_channel.sv
// One debounced button: synchroniser, stability FSM/counter, registered press/release pulses.
// With DEBOUNCE_AUTOREPEAT_EN defined, a hold counter re-fires the press pulse while held.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 50_000_000,
  parameter int   SYNC_STAGES     = 2,
  parameter logic ACTIVE_LEVEL    = 1'b1,
  parameter int   REPEAT_DELAY    = 25_000_000,
  parameter int   REPEAT_PERIOD   = 5_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  db_state_t              r_state;
  logic [CW-1:0]          r_cnt;
  logic                   r_level;
  logic                   r_press;
  logic                   r_release;
  logic                   w_s;

`ifdef DEBOUNCE_AUTOREPEAT_EN
  // Reloading to DELAY-PERIOD after each repeat makes later repeats PERIOD apart.
  localparam logic [CW-1:0] HOLD_LAST   = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] HOLD_RELOAD = CW'(REPEAT_DELAY - REPEAT_PERIOD);
  logic [CW-1:0] r_hold;
`endif

  assign w_s = (r_sync[SYNC_STAGES-1] == ACTIVE_LEVEL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync    <= {SYNC_STAGES{~ACTIVE_LEVEL}};
      r_state   <= DB_STABLE;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
`ifdef DEBOUNCE_AUTOREPEAT_EN
      r_hold    <= '0;
`endif
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], i_btn};
      r_press   <= 1'b0;
      r_release <= 1'b0;
`ifdef DEBOUNCE_AUTOREPEAT_EN
      if (r_level) begin
        if (r_hold == HOLD_LAST) begin
          r_hold  <= HOLD_RELOAD;
          r_press <= 1'b1;
        end else begin
          r_hold  <= r_hold + CNT_ONE;
        end
      end else begin
        r_hold <= '0;
      end
`endif
      unique case (r_state)
        DB_STABLE: begin
          if (w_s != r_level) begin
            r_state <= DB_COUNTING;
            r_cnt   <= CNT_ONE;
          end else begin
            r_cnt   <= '0;
          end
        end
        DB_COUNTING: begin
          if (w_s == r_level) begin
            r_state <= DB_STABLE;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            // Accept: a release here also overrides any repeat pulse due this cycle.
            r_level   <= w_s;
            r_state   <= DB_STABLE;
            r_cnt     <= '0;
            r_press   <= w_s;
            r_release <= ~w_s;
`ifdef DEBOUNCE_AUTOREPEAT_EN
            r_hold    <= '0;
`endif
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_state <= DB_STABLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule

// File: rtl/debounce_bank.sv
// N-channel front-panel button debouncer; one independent channel per input plus an any-press flag.
// Optional build macro: DEBOUNCE_AUTOREPEAT_EN (auto-repeat press pulses while held).
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int   N_CH            = 4,
  parameter int   DEBOUNCE_CYCLES = 50_000_000,
  parameter int   SYNC_STAGES     = 2,
  parameter logic ACTIVE_LEVEL    = 1'b1,
  parameter int   REPEAT_DELAY    = 25_000_000,
  parameter int   REPEAT_PERIOD   = 5_000_000
) (
  input  logic           clk,
  input  logic           rst_n,
  debounce_bank_if.slave bus
);

  logic [N_CH-1:0] w_level;
  logic [N_CH-1:0] w_press;
  logic [N_CH-1:0] w_release;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES),
      .ACTIVE_LEVEL    (ACTIVE_LEVEL),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_btn     (bus.btn_in[g]),
      .o_level   (w_level[g]),
      .o_press   (w_press[g]),
      .o_release (w_release[g])
    );
  end

  assign bus.btn_level   = w_level;
  assign bus.btn_press   = w_press;
  assign bus.btn_release = w_release;
  assign bus.any_press   = |w_press;

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank: N_CH=2, DEBOUNCE_CYCLES=8, SYNC_STAGES=2, active-high buttons.
module tb_debounce_bank;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  debounce_bank_if #(.N_CH(2)) bif ();

  debounce_bank #(
    .N_CH            (2),
    .DEBOUNCE_CYCLES (8),
    .SYNC_STAGES     (2),
    .ACTIVE_LEVEL    (1'b1),
    .REPEAT_DELAY    (20),
    .REPEAT_PERIOD   (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {level, press, release, any_press} packed for one-shot comparison
  function automatic logic [31:0] outs();
    return {25'd0, bif.btn_level, bif.btn_press, bif.btn_release, bif.any_press};
  endfunction

  function automatic logic [31:0] want(input logic [1:0] lvl, input logic [1:0] prs,
                                       input logic [1:0] rel);
    return {25'd0, lvl, prs, rel, |prs};
  endfunction

  task automatic quiet(input int n, input logic [1:0] lvl, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      chk(tag, outs(), want(lvl, 2'b00, 2'b00));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset with both buttons held; press only after full qualification
    bif.btn_in = 2'b11;
    #1;
    chk("reset_async", outs(), want(2'b00, 2'b00, 2'b00));
    quiet(3, 2'b00, "reset_hold");
    rst_n = 1'b1;
    quiet(9, 2'b00, "reset_exit_quiet");
    tick();
    chk("reset_exit_press", outs(), want(2'b11, 2'b11, 2'b00));
    tick();
    chk("reset_exit_after", outs(), want(2'b11, 2'b00, 2'b00));
    bif.btn_in = 2'b00;
    quiet(9, 2'b11, "both_release_quiet");
    tick();
    chk("both_release", outs(), want(2'b00, 2'b00, 2'b11));

    // 2: clean press and release on ch0
    quiet(3, 2'b00, "idle");
    bif.btn_in = 2'b01;
    quiet(9, 2'b00, "clean_wait");
    tick();
    chk("clean_press", outs(), want(2'b01, 2'b01, 2'b00));
    tick();
    chk("clean_press_1cyc", outs(), want(2'b01, 2'b00, 2'b00));
    bif.btn_in = 2'b00;
    quiet(9, 2'b01, "clean_rel_wait");
    tick();
    chk("clean_release", outs(), want(2'b00, 2'b00, 2'b01));

    // 3: bounce on ch0, toggling every 3 cycles, then settle high
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) bif.btn_in[0] = ~bif.btn_in[0];
      tick();
      chk("bounce_quiet", outs(), want(2'b00, 2'b00, 2'b00));
    end
    bif.btn_in = 2'b01;
    quiet(9, 2'b00, "bounce_settle");
    tick();
    chk("bounce_press", outs(), want(2'b01, 2'b01, 2'b00));
    bif.btn_in = 2'b00;
    quiet(9, 2'b01, "bounce_rel_wait");
    tick();
    chk("bounce_release", outs(), want(2'b00, 2'b00, 2'b01));

    // 4: 7-cycle glitch rejected, 8-cycle high accepted, then 8-cycle low released
    bif.btn_in = 2'b10;
    for (int i = 1; i <= 16; i++) begin
      if (i == 8) bif.btn_in = 2'b00;
      tick();
      chk("glitch7", outs(), want(2'b00, 2'b00, 2'b00));
    end
    bif.btn_in = 2'b10;
    for (int i = 1; i <= 20; i++) begin
      if (i == 9) bif.btn_in = 2'b00;
      tick();
      chk("pulse8", outs(), want((i >= 10 && i < 18) ? 2'b10 : 2'b00,
                                 (i == 10) ? 2'b10 : 2'b00,
                                 (i == 18) ? 2'b10 : 2'b00));
    end

    // 5: reset mid-qualification at cnt=5, input still held
    bif.btn_in = 2'b01;
    quiet(7, 2'b00, "pre_reset_count");
    rst_n = 1'b0;
    #1;
    chk("midcount_reset", outs(), want(2'b00, 2'b00, 2'b00));
    quiet(2, 2'b00, "midcount_reset_hold");
    rst_n = 1'b1;
    quiet(9, 2'b00, "midcount_restart");
    tick();
    chk("midcount_press", outs(), want(2'b01, 2'b01, 2'b00));
    bif.btn_in = 2'b00;
    quiet(9, 2'b01, "midcount_rel_wait");
    tick();
    chk("midcount_release", outs(), want(2'b00, 2'b00, 2'b01));

`ifdef DEBOUNCE_AUTOREPEAT_EN
    // 6: hold ch0 for 60 cycles: press at accept, +20, then every 5; none on release
    bif.btn_in = 2'b01;
    for (int i = 1; i <= 80; i++) begin
      if (i == 61) bif.btn_in = 2'b00;
      tick();
      chk("repeat", outs(),
          want((i >= 10 && i < 70) ? 2'b01 : 2'b00,
               ((i == 10) || (i >= 30 && i < 70 && (i - 30) % 5 == 0)) ? 2'b01 : 2'b00,
               (i == 70) ? 2'b01 : 2'b00));
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
